// File: rtl/formula_2_inv_pipe.sv
// rtl/formula_2_inv_pipe.sv - pipelined inverse of formula_2: smallest c with f(a,b,c) >= y
module formula_2_inv_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        arg_vld,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] y,
  output logic        res_vld,
  output logic [31:0] res,
  output logic        res_ovf
);

  logic        v0, v1, v2, v3, v4;
  logic [31:0] a0, b0, y0;
  logic [63:0] s1;
  logic [31:0] a1, b1;
  logic [16:0] t1;
  logic        ovf2;
  logic [31:0] b2;
  logic [33:0] s2;
  logic        ovf3;
  logic [31:0] b3;
  logic [15:0] t2;
  logic        ovf4;

  logic [63:0] sq1;
  logic [63:0] d1;
  logic        under1, big1;
  logic [16:0] t1_n;
  logic [33:0] sq2;
  logic [33:0] d2;
  logic        under2, big2;
  logic [15:0] t2_n;
  logic [31:0] c_n;

  // Underflow clamps to 0 (any inner value satisfies the bound); too-large
  // intermediates flag overflow and also clamp so downstream stays in range.
  always_comb begin
    sq1    = 64'(y0) * 64'(y0);
    d1     = s1 - 64'(a1);
    under1 = s1 < 64'(a1);
    big1   = !under1 && (d1[63:17] != '0);
    t1_n   = (under1 || big1) ? 17'd0 : d1[16:0];
    sq2    = 34'(t1) * 34'(t1);
    d2     = s2 - 34'(b3);
    under2 = s2 < 34'(b3);
    big2   = !under2 && (d2[33:16] != '0);
    t2_n   = (under2 || big2) ? 16'd0 : d2[15:0];
    c_n    = 32'(t2) * 32'(t2);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      v4      <= 1'b0;
      res_vld <= 1'b0;
      res     <= 32'd0;
      res_ovf <= 1'b0;
    end else begin
      v0      <= arg_vld;
      v1      <= v0;
      v2      <= v1;
      v3      <= v2;
      v4      <= v3;
      res_vld <= v4;
      if (v4) begin
        res     <= ovf4 ? 32'hFFFF_FFFF : c_n;
        res_ovf <= ovf4;
      end
    end
  end

  // Data registers load only behind their stage valid to save switching.
  always_ff @(posedge clk) begin
    if (arg_vld) begin
      a0 <= a;
      b0 <= b;
      y0 <= y;
    end
    if (v0) begin
      s1 <= sq1;
      a1 <= a0;
      b1 <= b0;
    end
    if (v1) begin
      t1   <= t1_n;
      ovf2 <= big1;
      b2   <= b1;
    end
    if (v2) begin
      s2   <= sq2;
      ovf3 <= ovf2;
      b3   <= b2;
    end
    if (v3) begin
      t2   <= t2_n;
      ovf4 <= ovf3 || big2;
    end
  end

endmodule

// File: tb/tb_formula_2_inv_pipe.sv
// tb/tb_formula_2_inv_pipe.sv - randomized self-checking bench for formula_2_inv_pipe
module tb_formula_2_inv_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        arg_vld;
  logic [31:0] a, b, y;
  logic        res_vld;
  logic [31:0] res;
  logic        res_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  bit          dl_v [6];
  logic [31:0] dl_a [6];
  logic [31:0] dl_b [6];
  logic [31:0] dl_y [6];
  logic [31:0] last_res;
  bit          last_ovf;

  always #5 clk = ~clk;

  formula_2_inv_pipe dut (
    .clk     (clk),
    .rst     (rst),
    .arg_vld (arg_vld),
    .a       (a),
    .b       (b),
    .y       (y),
    .res_vld (res_vld),
    .res     (res),
    .res_ovf (res_ovf)
  );

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'hFFFF_FFFF;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic longint unsigned fwd(input longint unsigned aa, bb, cc);
    return isqrt(aa + isqrt(bb + isqrt(cc)));
  endfunction

  // Reference: c = t2^2 with t1 = max(y^2-a,0), t2 = max(t1^2-b,0), bounded widths.
  task automatic model(input logic [31:0] aa, bb, yy, output logic [31:0] c, output bit o);
    longint unsigned sy, t1m, t2m;
    sy  = longint'(yy) * longint'(yy);
    t1m = (sy > aa) ? sy - aa : 0;
    o   = 1'b0;
    c   = 32'd0;
    if (t1m >= 64'd131072) o = 1'b1;
    else begin
      t2m = (t1m * t1m > bb) ? t1m * t1m - bb : 0;
      if (t2m >= 64'd65536) o = 1'b1;
      else c = 32'(t2m * t2m);
    end
    if (o) c = 32'hFFFF_FFFF;
  endtask

  task automatic check_out();
    logic [31:0] ec;
    bit          eo;
    chk("res_vld", res_vld, dl_v[5]);
    if (dl_v[5]) begin
      model(dl_a[5], dl_b[5], dl_y[5], ec, eo);
      chk("res", res, ec);
      chk("res_ovf", res_ovf, eo);
      if (!eo) chk("fwd_ge_y", fwd(dl_a[5], dl_b[5], res) >= dl_y[5], 1);
      if (!eo && ec != 0) chk("minimal", fwd(dl_a[5], dl_b[5], ec - 1) < dl_y[5], 1);
      last_res = ec;
      last_ovf = eo;
    end else begin
      chk("hold_res", res, last_res);
      chk("hold_ovf", res_ovf, last_ovf);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] aa, bb, yy);
    arg_vld = v;
    a = aa;
    b = bb;
    y = yy;
    @(posedge clk);
    for (int i = 5; i > 0; i--) begin
      dl_v[i] = dl_v[i-1];
      dl_a[i] = dl_a[i-1];
      dl_b[i] = dl_b[i-1];
      dl_y[i] = dl_y[i-1];
    end
    dl_v[0] = v;
    dl_a[0] = aa;
    dl_b[0] = bb;
    dl_y[0] = yy;
    #1;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    arg_vld = 1'b1;
    y       = 32'd5;
    @(posedge clk);
    for (int i = 0; i < 6; i++) dl_v[i] = 1'b0;
    last_res = 32'd0;
    last_ovf = 1'b0;
    #1;
    chk("rst_vld", res_vld, 0);
    chk("rst_res", res, 0);
    chk("rst_ovf", res_ovf, 0);
    rst = 1'b1;
  endtask

  task automatic directed(input logic [31:0] aa, bb, yy, input logic [31:0] er, input bit eo);
    cycle(1'b1, aa, bb, yy);
    idle(5);
    chk("dir_vld", res_vld, 1);
    chk("dir_res", res, er);
    chk("dir_ovf", res_ovf, eo);
  endtask

  task automatic rnd(output logic [31:0] aa, bb, yy);
    case ($urandom_range(0, 3))
      0: begin yy = $urandom_range(0, 20);   aa = $urandom_range(0, 500); bb = $urandom_range(0, 100000); end
      1: begin yy = $urandom_range(0, 3000); aa = $urandom;              bb = $urandom;                 end
      2: begin yy = $urandom;                aa = $urandom;              bb = $urandom;                 end
      default: begin yy = 32'd0;             aa = $urandom;              bb = $urandom;                 end
    endcase
  endtask

  initial begin
    logic [31:0] ra, rb, ry;
    int sent;
    for (int i = 0; i < 6; i++) dl_v[i] = 1'b0;
    last_res = 32'd0;
    last_ovf = 1'b0;
    arg_vld  = 1'b0;
    a = 0; b = 0; y = 0;
    rst = 1'b0;
    @(posedge clk);
    do_reset();

    directed(32'd5, 32'd2, 32'd3, 32'd196, 1'b0);
    directed(32'd10, 32'd0, 32'd2, 32'd0, 1'b0);
    directed(32'd0, 32'd300, 32'd4, 32'd0, 1'b0);
    directed(32'd0, 32'd0, 32'd1000, 32'hFFFF_FFFF, 1'b1);
    directed(32'd0, 32'd0, 32'd16, 32'hFFFF_FFFF, 1'b1);
    directed(32'd0, 32'd1, 32'd16, 32'hFFFE_0001, 1'b0);
    directed(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);

    for (int i = 0; i < 100; i++) begin
      rnd(ra, rb, ry);
      cycle(1'b1, ra, rb, ry);
    end
    sent = 0;
    while (sent < 100) begin
      if ($urandom_range(0, 2) != 0) begin
        rnd(ra, rb, ry);
        cycle(1'b1, ra, rb, ry);
        sent++;
      end else begin
        cycle(1'b0, $urandom, $urandom, $urandom);
      end
    end
    idle(6);

    for (int i = 0; i < 3; i++) begin
      rnd(ra, rb, ry);
      cycle(1'b1, ra, rb, ry);
    end
    do_reset();
    idle(7);
    directed(32'd5, 32'd2, 32'd3, 32'd196, 1'b0);

    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
